// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: owner FSM encoding and bus field widths.
package mem_arb_pkg;

    localparam int FUNCT3_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle linking two requesters and a one-cycle-latency shared memory to mem_arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    logic                m0_req;
    logic                m0_we;
    logic                m0_lock;
    logic [ADDR_W-1:0]   m0_addr;
    logic [DATA_W-1:0]   m0_wdata;
    logic [FUNCT3_W-1:0] m0_funct3;
    logic                m0_gnt;
    logic                m0_rvalid;
    logic [DATA_W-1:0]   m0_rdata;

    logic                m1_req;
    logic                m1_we;
    logic                m1_lock;
    logic [ADDR_W-1:0]   m1_addr;
    logic [DATA_W-1:0]   m1_wdata;
    logic [FUNCT3_W-1:0] m1_funct3;
    logic                m1_gnt;
    logic                m1_rvalid;
    logic [DATA_W-1:0]   m1_rdata;

    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_ra;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic [FUNCT3_W-1:0] mem_funct3;
    logic [DATA_W-1:0]   mem_rd;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_funct3,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_funct3,
        input  mem_rd,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_wen, mem_ra, mem_wa, mem_wd, mem_funct3
    );

    // Requesters plus memory side
    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata, m0_funct3,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_funct3,
        output mem_rd,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_wen, mem_ra, mem_wa, mem_wd, mem_funct3
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one shared memory with combinational grant and lock support.
// MEM_ARB_RR_EN: defined -> round-robin in IDLE plus MAX_HOLD forcing; undefined -> m0 fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic                gnt0;
    logic                gnt1;
    logic                beat_lock;
    logic                lock_seq;
    logic                lock_seq_nxt;
    logic                pick_m1;
    logic                hold_force;
    logic                rvld0_p1;
    logic                rvld1_p1;

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [FUNCT3_W-1:0] sel_funct3;

`ifdef MEM_ARB_RR_EN
    localparam int               CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             rr_prio;
    logic             rr_prio_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= HOLD_LAST) ? c : c + CNT_W'(1);
    endfunction

    // Count unlocked beats of the current owner; a beat granted from IDLE opens the count.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        rr_prio_nxt  = rr_prio;
        if (state_nxt != state) begin
            hold_cnt_nxt = (state == IDLE && (gnt0 || gnt1) && !beat_lock) ? sat_inc(CNT_W'(0)) : '0;
            if (state_nxt == OWN0) begin
                rr_prio_nxt = 1'b1;
            end else if (state_nxt == OWN1) begin
                rr_prio_nxt = 1'b0;
            end
        end else if ((gnt0 || gnt1) && !beat_lock) begin
            hold_cnt_nxt = sat_inc(hold_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            rr_prio  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            rr_prio  <= rr_prio_nxt;
        end
    end

    assign pick_m1    = rr_prio;
    assign hold_force = (hold_cnt >= HOLD_LAST);
`else
    assign pick_m1    = 1'b0;
    assign hold_force = 1'b0;
`endif

    // Owner FSM and grant decode.
    // The unlocked beat that closes a locked run hands over directly, so an atomic
    // sequence never extends ownership past its own end while the other side waits.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_req && (!bus.m1_req || !pick_m1)) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                end else if (bus.m1_req) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!bus.m0_req) begin
                    state_nxt = IDLE;
                end else begin
                    gnt0 = 1'b1;
                    if (!bus.m0_lock) begin
                        if (!bus.m1_req) begin
                            state_nxt = IDLE;
                        end else if (lock_seq || hold_force) begin
                            state_nxt = OWN1;
                        end
                    end
                end
            end
            OWN1: begin
                if (!bus.m1_req) begin
                    state_nxt = IDLE;
                end else begin
                    gnt1 = 1'b1;
                    if (!bus.m1_lock) begin
                        if (!bus.m0_req) begin
                            state_nxt = IDLE;
                        end else if (lock_seq || hold_force) begin
                            state_nxt = OWN0;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        beat_lock    = gnt1 ? bus.m1_lock : (gnt0 & bus.m0_lock);
        lock_seq_nxt = lock_seq;
        if (gnt0 || gnt1) begin
            lock_seq_nxt = beat_lock;
        end else if (state_nxt == IDLE) begin
            lock_seq_nxt = 1'b0;
        end
    end

    // Stage p0 -> p1: owner state and the one-cycle read return tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_seq <= 1'b0;
            rvld0_p1 <= 1'b0;
            rvld1_p1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_seq <= lock_seq_nxt;
            rvld0_p1 <= gnt0 & ~bus.m0_we;
            rvld1_p1 <= gnt1 & ~bus.m1_we;
        end
    end

    // Memory-side mux: everything reads as zero when nobody is granted.
    always_comb begin
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_funct3 = '0;
        if (gnt0) begin
            sel_we     = bus.m0_we;
            sel_addr   = bus.m0_addr;
            sel_wdata  = bus.m0_wdata;
            sel_funct3 = bus.m0_funct3;
        end else if (gnt1) begin
            sel_we     = bus.m1_we;
            sel_addr   = bus.m1_addr;
            sel_wdata  = bus.m1_wdata;
            sel_funct3 = bus.m1_funct3;
        end
    end

    assign bus.m0_gnt     = gnt0;
    assign bus.m1_gnt     = gnt1;
    assign bus.mem_wen    = sel_we;
    assign bus.mem_ra     = sel_addr;
    assign bus.mem_wa     = sel_addr;
    assign bus.mem_wd     = sel_wdata;
    assign bus.mem_funct3 = sel_funct3;

    assign bus.m0_rvalid  = rvld0_p1;
    assign bus.m1_rvalid  = rvld1_p1;
    assign bus.m0_rdata   = rvld0_p1 ? bus.mem_rd : '0;
    assign bus.m1_rdata   = rvld1_p1 ? bus.mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed traffic, expected grants/reads queued, negedge monitor compares.
module tb_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [1:0]  id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          cyc;
    } gnt_exp_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          cyc;
    } rv_exp_t;

    gnt_exp_t gq[$];
    rv_exp_t  rq[$];
    int       cyc   = 0;
    int       tests = 0;
    int       fails = 0;
    bit       done  = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Synchronous memory model: one-cycle read latency
    always @(posedge clk) begin
        bus.mem_rd <= pat(bus.mem_ra);
        cyc        <= cyc + 1;
    end

    task automatic drive(input int id, input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
        if (id == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
            bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_funct3 = f3;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
            bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_funct3 = f3;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_g(input int id, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3, input int at);
        gq.push_back('{(id == 0) ? 2'b01 : 2'b10, we, addr, wdata, f3, at});
    endtask

    task automatic exp_r(input int id, input logic [31:0] addr, input int at);
        rq.push_back('{(id == 0) ? 2'b01 : 2'b10, pat(addr), at});
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        idle_all();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every cycle, compare grants, idle memory bus and read returns
    always @(negedge clk) begin
        gnt_exp_t   ge;
        rv_exp_t    re;
        logic [1:0] gid;
        logic [1:0] rid;
        gid = {bus.m1_gnt, bus.m0_gnt};
        rid = {bus.m1_rvalid, bus.m0_rvalid};

        tests++;
        if (gid != 2'b00) begin
            if (gq.size() == 0) begin
                fails++;
                $display("FAIL gnt_unexpected cyc=%0d: actual gnt=%b ra=%h, required no grant", cyc, gid, bus.mem_ra);
            end else begin
                ge = gq.pop_front();
                if (gid !== ge.id || cyc != ge.cyc || bus.mem_wen !== ge.we || bus.mem_ra !== ge.addr ||
                    bus.mem_wa !== ge.addr || bus.mem_wd !== ge.wdata || bus.mem_funct3 !== ge.f3) begin
                    fails++;
                    $display("FAIL gnt cyc=%0d: actual gnt=%b wen=%b ra=%h wa=%h wd=%h f3=%b, required cyc=%0d gnt=%b wen=%b addr=%h wd=%h f3=%b",
                             cyc, gid, bus.mem_wen, bus.mem_ra, bus.mem_wa, bus.mem_wd, bus.mem_funct3,
                             ge.cyc, ge.id, ge.we, ge.addr, ge.wdata, ge.f3);
                end
            end
        end else if ({bus.mem_wen, bus.mem_ra, bus.mem_wa, bus.mem_wd, bus.mem_funct3} !== '0) begin
            fails++;
            $display("FAIL mem_idle cyc=%0d: actual wen=%b ra=%h wa=%h wd=%h f3=%b, required all zero",
                     cyc, bus.mem_wen, bus.mem_ra, bus.mem_wa, bus.mem_wd, bus.mem_funct3);
        end

        tests++;
        if (rid != 2'b00) begin
            if (rq.size() == 0) begin
                fails++;
                $display("FAIL rvalid_unexpected cyc=%0d: actual rvalid=%b, required none", cyc, rid);
            end else begin
                re = rq.pop_front();
                if (rid !== re.id || cyc != re.cyc ||
                    (re.id == 2'b01 && (bus.m0_rdata !== re.data || bus.m1_rdata !== '0)) ||
                    (re.id == 2'b10 && (bus.m1_rdata !== re.data || bus.m0_rdata !== '0))) begin
                    fails++;
                    $display("FAIL rvalid cyc=%0d: actual rvalid=%b rdata0=%h rdata1=%h, required cyc=%0d rvalid=%b rdata=%h",
                             cyc, rid, bus.m0_rdata, bus.m1_rdata, re.cyc, re.id, re.data);
                end
            end
        end else if ({bus.m0_rdata, bus.m1_rdata} !== '0) begin
            fails++;
            $display("FAIL rdata_idle cyc=%0d: actual rdata0=%h rdata1=%h, required 0", cyc, bus.m0_rdata, bus.m1_rdata);
        end

        if (done) begin
            tests++;
            if (gq.size() != 0) begin
                fails++;
                $display("FAIL gnt_missing: actual %0d grants never seen, required 0", gq.size());
            end
            tests++;
            if (rq.size() != 0) begin
                fails++;
                $display("FAIL rvalid_missing: actual %0d reads never returned, required 0", rq.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        int c;
        idle_all();
        // A request during reset must not be granted
        drive(0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 3'b010);
        repeat (3) step();
        idle_all();
        rst_n = 1'b1;
        step();

        // Single m0 read
        c = cyc;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 3'b010);
        exp_g(0, 1'b0, 32'h10, 32'h0, 3'b010, c);
        exp_r(0, 32'h10, c + 1);
        step();
        idle_all();
        step(); step();

        // Single m0 write
        c = cyc;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h24, 32'hDEADBEEF, 3'b010);
        exp_g(0, 1'b1, 32'h24, 32'hDEADBEEF, 3'b010, c);
        step();
        idle_all();
        step(); step();

        // Back-to-back m0 reads, one grant per cycle
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 3'b100);
            exp_g(0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 3'b100, c + i);
            exp_r(0, 32'h100 + 32'(4 * i), c + i + 1);
            step();
        end
        idle_all();
        step(); step();

        // m1 write then read on consecutive cycles
        c = cyc;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678, 3'b001);
        exp_g(1, 1'b1, 32'h40, 32'h12345678, 3'b001, c);
        step();
        drive(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 3'b000);
        exp_g(1, 1'b0, 32'h44, 32'h0, 3'b000, c + 1);
        exp_r(1, 32'h44, c + 2);
        step();
        idle_all();
        step(); step();

        // Contention from reset, then a second contention after m0 releases
        rst_pulse();
        c = cyc;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 3'b010);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 3'b010);
        exp_g(0, 1'b0, 32'h200, 32'h0, 3'b010, c);
        exp_r(0, 32'h200, c + 1);
        step();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 3'b010);
`ifdef MEM_ARB_RR_EN
        exp_g(1, 1'b0, 32'h300, 32'h0, 3'b010, c + 2);
        exp_r(1, 32'h300, c + 3);
        step();
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step();
        exp_g(0, 1'b0, 32'h204, 32'h0, 3'b010, c + 4);
        exp_r(0, 32'h204, c + 5);
`else
        exp_g(0, 1'b0, 32'h204, 32'h0, 3'b010, c + 2);
        exp_r(0, 32'h204, c + 3);
        step();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step();
        exp_g(1, 1'b0, 32'h300, 32'h0, 3'b010, c + 4);
        exp_r(1, 32'h300, c + 5);
`endif
        step();
        idle_all();
        step(); step();

        // m0 streams unlocked writes while m1 waits
        rst_pulse();
        c = cyc;
        for (int k = 0; k <= 10; k++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'hA000_0000 + 32'(k), 3'b010);
            if (k <= 8) drive(1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 3'b010);
            else        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
`ifdef MEM_ARB_RR_EN
            if (k <= 7 || k == 10) begin
                exp_g(0, 1'b1, 32'h400 + 32'(4 * k), 32'hA000_0000 + 32'(k), 3'b010, c + k);
            end else if (k == 8) begin
                exp_g(1, 1'b0, 32'h500, 32'h0, 3'b010, c + 8);
                exp_r(1, 32'h500, c + 9);
            end
`else
            exp_g(0, 1'b1, 32'h400 + 32'(4 * k), 32'hA000_0000 + 32'(k), 3'b010, c + k);
`endif
            step();
        end
        idle_all();
        step(); step();

        // m1 locked run of 20 beats; m0 waits until the run ends
        c = cyc;
        for (int k = 0; k <= 21; k++) begin
            if (k <= 20) begin
                drive(1, 1'b1, 1'b1, (k < 20), 32'h700 + 32'(4 * k), 32'(k), 3'b010);
                exp_g(1, 1'b1, 32'h700 + 32'(4 * k), 32'(k), 3'b010, c + k);
            end else begin
                drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
            end
            if (k >= 1) drive(0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 3'b000);
            if (k == 21) begin
                exp_g(0, 1'b0, 32'h600, 32'h0, 3'b000, c + 21);
                exp_r(0, 32'h600, c + 22);
            end
            step();
        end
        idle_all();
        step(); step();

        // Reset while an m0 read is in flight: the read is dropped
        c = cyc;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 3'b010);
        exp_g(0, 1'b0, 32'h800, 32'h0, 3'b010, c);
        step();
        rst_n = 1'b0;
        idle_all();
        step(); step();
        rst_n = 1'b1;
        c = cyc;
        drive(1, 1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 3'b010);
        exp_g(1, 1'b0, 32'h900, 32'h0, 3'b010, c);
        exp_r(1, 32'h900, c + 1);
        step();
        idle_all();
        step(); step(); step();

        done = 1'b1;
        #1000;
        $display("FAIL summary_timeout: monitor did not close the run");
        $fatal(1, "bench did not terminate");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MAX_HOLD, default 8, maximum consecutive unlocked grant cycles before ownership is forced to the other requester.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_req/m1_req  input  1  requester N presents a transaction this cycle.
REQ-007 SHALL have ports m0_we/m1_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_lock/m1_lock  input  1  keep ownership after this beat (atomic sequence).
REQ-009 SHALL have ports m0_addr/m1_addr  input  ADDR_W  byte address.
REQ-010 SHALL have ports m0_wdata/m1_wdata  input  DATA_W  write data.
REQ-011 SHALL have ports m0_funct3/m1_funct3  input  3  access size/sign, passed to memory unchanged.
REQ-012 SHALL have ports m0_gnt/m1_gnt  output  1  transaction accepted this cycle.
REQ-013 SHALL have ports m0_rvalid/m1_rvalid  output  1  read data valid.
REQ-014 SHALL have ports m0_rdata/m1_rdata  output  DATA_W  read data.
REQ-015 SHALL have ports mem_wen  output  1, mem_ra/mem_wa  output  ADDR_W, mem_wd  output  DATA_W, mem_funct3  output  3, mem_rd  input  DATA_W  to the shared memory.

Function
REQ-016 SHALL implement owner FSM with states IDLE, OWN0, OWN1.
REQ-017 IDLE: if any req, pick winner per REQ-024/025, go to OWNn, grant that request in the same cycle (combinational gnt).
REQ-018 OWNn: gnt only to mN while mN_req=1; other requester's gnt SHALL be 0.
REQ-019 OWNn -> IDLE when mN_req=0, or when a granted beat has lock=0 and the other requester is idle.
REQ-020 OWNn -> OWN(other) directly when a granted beat has lock=0 and the other requester is requesting, and hold counter reached MAX_HOLD-1; otherwise stay.
REQ-021 Hold counter: clears on ownership change; increments per granted unlocked beat; saturates; locked beats never force release.
REQ-022 Granted beat: mem_ra=mem_wa=addr, mem_wd=wdata, mem_funct3=funct3, mem_wen=we; with no grant mem_wen=0 and address/data outputs 0.
REQ-023 Reads: memory read latency is one cycle; the rvalid of the requester granted a read in cycle T SHALL be 1 in cycle T+1, rdata=mem_rd; rdata SHALL be 0 when rvalid=0.
REQ-024 Simultaneous req in IDLE: winner is the requester not granted most recently (round-robin pointer, updated on every ownership change).
REQ-025 Writes produce no rvalid; back-to-back grants every cycle SHALL be supported.

Reset
REQ-026 On rst_n=0: state IDLE, hold counter 0, round-robin pointer favours m0, all gnt/rvalid/mem_wen 0, all data/address outputs 0.
REQ-027 Read in flight when reset asserts SHALL be discarded; no rvalid after reset release.

Configuration
REQ-028 Macro MEM_ARB_RR_EN: defined -> round-robin per REQ-024 and MAX_HOLD forcing per REQ-020; undefined -> fixed priority m0 over m1 in IDLE and REQ-020 forcing disabled (owner keeps grant while requesting).

Structure
REQ-029 Shared package mem_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the funct3 width constant.
REQ-030 No sub-module; single module with separate registered FSM and combinational mux.

Verification
REQ-031 m0 read addr 0x10 alone -> m0_gnt same cycle, mem_ra=0x10, m0_rvalid=1 next cycle with mem_rd value.
REQ-032 m0 and m1 req together from reset, no lock -> m0 granted first, m1 after m0 releases; with MEM_ARB_RR_EN next contention goes to m1.
REQ-033 m0 continuous unlocked writes, m1 requesting, MAX_HOLD=8 -> m0 gets exactly 8 grants, then m1 owns.
REQ-034 m1 lock=1 for 20 beats while m0 requests -> m0_gnt=0 throughout; m0 granted on the cycle after m1's first lock=0 beat.
REQ-035 rst_n low one cycle after m0 read grant -> m0_rvalid stays 0, FSM IDLE, mem_wen 0.
REQ-036 Write grant (we=1, wdata 0xDEADBEEF, funct3 3'b010) -> mem_wen=1, mem_wd=0xDEADBEEF, mem_funct3=3'b010, no rvalid.
